uart_operand_rx: RTL and testbench
==================================

# uart_operand_rx

Upstream operand-capture stage for the 381-bit adder datapath. Receives a wide operand over a UART serial line (8N1, LSB first) and assembles it into a parallel `RxData` word that feeds the adder's `A`/`B` inputs. A `done` flag tells the adder control that the operand is valid. Two instances share the single `RxD` pin; each is armed by its own `enable`.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz
- `BAUD`, 9600: serial bit rate
- `DATA_W`, 381: operand width in bits
- `clk`  input  1  system clock, rising edge
- `reset`  input  1  asynchronous, active-high reset
- `enable`  input  1  level; a rising edge arms a new capture, and low aborts it
- `RxD`  input  1  serial line, idle high, asynchronous to `clk`
- `RxData`  output  DATA_W  assembled operand
- `done`  output  1  operand complete and valid; sticky
- `frame_err`  output  1  sticky; a stop bit was sampled low during the current capture

## Operation
- Derived constants:
  - `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer division
  - `NUM_BYTES = ceil(DATA_W/8)`, which is 48 at the default width
- `RxD` passes through a 2-flop synchronizer. All logic uses the synchronized value.
- Bit-level FSM:
  - IDLE: capture not armed.
  - HUNT: waiting for line low.
  - START: counts `CLKS_PER_BIT/2`, then samples. If the sample is high, it was a false start: go back to HUNT. Otherwise go to DATA.
  - DATA: 8 samples spaced `CLKS_PER_BIT` apart, LSB first.
  - STOP: one sample `CLKS_PER_BIT` later.
    - High: commit the byte, then go to HUNT, or to DONE on the last byte.
    - Low: set `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: waits for the line to go high, then HUNT.
  - DONE: terminal state until re-armed.
- Byte order: the little-endian byte index is `k` (0..NUM_BYTES-1).
  - Byte `k` is written to `RxData[8k+7:8k]`.
  - For the last byte, only the low `DATA_W-8*(NUM_BYTES-1)` bits are kept (5 bits at the default width). The upper bits are dropped.
- Arming (rising edge of `enable`, from any state): byte count := 0, `done` := 0, `frame_err` := 0, FSM := HUNT. `RxData` is not cleared.
- `enable` low in any state other than DONE aborts the capture:
  - FSM := IDLE and the byte count is cleared.
  - `done` stays 0. `RxData` keeps its partial content, which is invalid.
- `enable` low in DONE has no effect: `done` and `RxData` hold.
- `RxData` bytes not yet written in the current capture keep their previous values.
- A frame error does not advance the byte count. The sender must resend that byte. `frame_err` stays set until the next arm or reset.

## Timing
- Reset values:
  - `RxData` = 0, `done` = 0, `frame_err` = 0
  - FSM = IDLE, byte count = 0, synchronizer flops = 1
- `RxD` to internal latency: 2 `clk` cycles.
- Start-bit midpoint sample: `CLKS_PER_BIT/2` cycles after the first synchronized low seen in HUNT.
- Each data-bit and stop-bit sample: `CLKS_PER_BIT` cycles after the previous sample.
- Byte commit into `RxData`: the cycle after a valid stop sample.
- `done` rises in the same cycle as the commit of byte NUM_BYTES-1.
- Arm edge and commit in the same cycle: arm wins and the byte is discarded.
- Reset mid-capture: all state returns to reset values immediately. No partial byte survives.
- Back-to-back frames with no idle gap: the stop-bit sample leads to HUNT, so a start edge that follows immediately is caught.

## Structure
- Package `uart_rx_pkg`:
  - state enum (IDLE, HUNT, START, DATA, STOP, WAIT_IDLE, DONE)
  - function computing `CLKS_PER_BIT` and `NUM_BYTES`
- Sub-module `uart_byte_rx`:
  - contains the synchronizer, baud counter and bit FSM
  - outputs `byte_valid`, `byte_data[7:0]` and `stop_err` as single-cycle pulses
- The top level holds the byte counter, the `enable` edge detect, the `RxData` write decoder and the sticky flags.

## Test plan
Bench parameters: `CLK_FREQ`=160, `BAUD`=10 (so `CLKS_PER_BIT`=16), `DATA_W`=381.
- **Full capture:** reset, arm, send 48 bytes of 0xFF.
  - `RxData` = all 1s (381 bits).
  - `done` rises at the last commit. `frame_err`=0.
- **Byte order:** send bytes 0x01, 0x02, …, 0x30.
  - `RxData[7:0]`=0x01, `RxData[15:8]`=0x02.
  - `RxData[380:376]`=0x30 & 0x1F = 0x10.
- **Framing error:** bad stop bit on byte 5, then resend byte 5 and the remaining bytes.
  - `frame_err`=1, byte count not advanced, `done` rises after 48 good bytes, data correct.
- **False start:** a 4-cycle low glitch on `RxD`.
  - No byte committed; the FSM returns to HUNT.
- **Abort and re-arm:** drop `enable` after 10 bytes, then re-arm and send 48 bytes of 0xA5.
  - `done`=0 during the abort.
  - Final `RxData` = 0xA5 pattern (low 5 bits of the top byte = 0x05). `done`=1.
- **Async reset mid-byte:** assert `reset` during the DATA state.
  - All outputs are 0 in the same cycle.
  - After release with `enable` high and no edge, the FSM stays IDLE.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constant helpers for the UART operand receiver.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
//
// Contents:
//   rx_state_e         bit-level receiver state encoding
//   calc_clks_per_bit  clock cycles per serial bit (integer division)
//   calc_num_bytes     bytes needed to carry an operand of a given width
//   calc_cnt_w         counter width able to hold 0..n-1 (minimum 1)
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HUNT      = 3'd1,
      START     = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5,
      DONE      = 3'd6
   } rx_state_e;

   function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   function automatic int calc_num_bytes(input int data_w);
      return (data_w + 7) / 8;
   endfunction

   function automatic int calc_cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronizer, baud counter and bit-level FSM.
// Latency: byte_valid pulses the cycle after the stop-bit sample (RxD adds 2 cycles of sync).
// Backpressure: none; byte_valid/stop_err are single-cycle pulses the consumer must take.
//
// Ports:
//   clk, reset     system clock, async active-high reset
//   arm_i          single-cycle pulse: restart hunting for a start bit from any state
//   enable_i       level; low aborts to IDLE unless the capture is already DONE
//   last_byte_i    the byte being received is the final one of the operand
//   rxd_i          raw serial line, idle high, asynchronous to clk
//   byte_valid     pulse: byte_data holds a byte whose stop bit was high
//   byte_data      received byte, LSB first on the line
//   stop_err       pulse: stop bit sampled low, byte discarded
module uart_byte_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       arm_i,
   input  logic       enable_i,
   input  logic       last_byte_i,
   input  logic       rxd_i,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       stop_err
);

   localparam int               CNT_W   = calc_cnt_w(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   // sync_q[1] is the only view of the line the FSM ever uses.
   logic [1:0]       sync_q;
   logic             rx_s;
   rx_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q     <= 2'b11;
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         stop_err   <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], rxd_i};
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;

         if (arm_i) begin
            state_q <= HUNT;
            cnt_q   <= '0;
         end else if (!enable_i && state_q != DONE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  cnt_q <= '0;
               end

               HUNT: begin
                  if (!rx_s) begin
                     state_q <= START;
                     cnt_q   <= '0;
                  end
               end

               // Re-check the line at mid start bit so a short glitch is
               // rejected rather than framed as a byte.
               START: begin
                  if (cnt_q == HALF_M1) begin
                     cnt_q <= '0;
                     if (rx_s) begin
                        state_q <= HUNT;
                     end else begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end

               // Right shift: after eight samples the first (LSB) bit sits in bit 0.
               DATA: begin
                  if (cnt_q == FULL_M1) begin
                     cnt_q     <= '0;
                     shift_q   <= {rx_s, shift_q[7:1]};
                     bit_idx_q <= bit_idx_q + 3'd1;
                     if (bit_idx_q == 3'd7) begin
                        state_q <= STOP;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end

               // The stop sample sits half a bit before the line could drop
               // again, so going straight to HUNT catches back-to-back frames.
               STOP: begin
                  if (cnt_q == FULL_M1) begin
                     cnt_q <= '0;
                     if (rx_s) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shift_q;
                        state_q    <= last_byte_i ? DONE : HUNT;
                     end else begin
                        stop_err <= 1'b1;
                        state_q  <= WAIT_IDLE;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end

               WAIT_IDLE: begin
                  if (rx_s) begin
                     state_q <= HUNT;
                  end
               end

               DONE: begin
                  cnt_q <= '0;
               end

               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/uart_operand_rx.sv
// Wide-operand UART capture: assembles NUM_BYTES serial bytes into RxData, little-endian.
// Latency: each byte lands in RxData one cycle after its stop-bit sample; done rises with the last.
// Backpressure: none; the serial sender is free-running, a bad stop bit must be resent.
//
// Ports:
//   clk, reset   system clock, async active-high reset
//   enable       rising edge arms a capture; low aborts it unless already done
//   RxD          serial line, 8N1, LSB first, idle high
//   RxData       assembled operand; byte k at [8k+7:8k], top byte truncated to fit
//   done         sticky: all bytes of the current capture committed
//   frame_err    sticky: a stop bit was sampled low during the current capture
module uart_operand_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600,
   parameter int DATA_W   = 381
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              RxD,
   output logic [DATA_W-1:0] RxData,
   output logic              done,
   output logic              frame_err
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
   localparam int NUM_BYTES    = calc_num_bytes(DATA_W);
   localparam int LAST_W       = DATA_W - 8 * (NUM_BYTES - 1);
   localparam int BCNT_W       = calc_cnt_w(NUM_BYTES);
   localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(NUM_BYTES - 1);

   logic              enable_q;
   logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic              done_q, done_d;
   logic              frame_err_q, frame_err_d;
   logic [DATA_W-1:0] rxdata_q, rxdata_d;

   logic              arm;
   logic              abort;
   logic              last_byte;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              stop_err;

   assign arm       = enable & ~enable_q;
   assign last_byte = (byte_cnt_q == LAST_IDX);

   // The byte receiver enters DONE on the final stop sample, one cycle before
   // its byte_valid pulse reaches here. Treat that pulse as already DONE so a
   // concurrent enable drop cannot discard a byte the receiver considers final.
   assign abort = ~enable & ~done_q & ~(byte_valid & last_byte);

   uart_byte_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_rx (
      .clk         (clk),
      .reset       (reset),
      .arm_i       (arm),
      .enable_i    (enable),
      .last_byte_i (last_byte),
      .rxd_i       (RxD),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .stop_err    (stop_err)
   );

   // Arm beats a same-cycle commit: the byte belongs to the old capture.
   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      done_d      = done_q;
      frame_err_d = frame_err_q;
      rxdata_d    = rxdata_q;

      if (arm) begin
         byte_cnt_d  = '0;
         done_d      = 1'b0;
         frame_err_d = 1'b0;
      end else if (abort) begin
         byte_cnt_d = '0;
      end else begin
         if (stop_err) begin
            frame_err_d = 1'b1;
         end
         if (byte_valid && !done_q) begin
            for (int k = 0; k < NUM_BYTES - 1; k++) begin
               if (byte_cnt_q == BCNT_W'(k)) begin
                  rxdata_d[8*k +: 8] = byte_data;
               end
            end
            // Top byte only carries the operand's leftover bits.
            if (last_byte) begin
               rxdata_d[DATA_W-1 -: LAST_W] = byte_data[LAST_W-1:0];
               done_d = 1'b1;
            end else begin
               byte_cnt_d = byte_cnt_q + 1'b1;
            end
         end
      end
   end

   // enable_q resets high so an enable held high across reset release is not
   // mistaken for an arming edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable_q    <= 1'b1;
         byte_cnt_q  <= '0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
         rxdata_q    <= '0;
      end else begin
         enable_q    <= enable;
         byte_cnt_q  <= byte_cnt_d;
         done_q      <= done_d;
         frame_err_q <= frame_err_d;
         rxdata_q    <= rxdata_d;
      end
   end

   assign RxData    = rxdata_q;
   assign done      = done_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_operand_rx.sv
// Bench for uart_operand_rx at CLKS_PER_BIT = 16, DATA_W = 381.
// Latency: a frame whose start bit is driven at cycle n commits at cycle n+156.
// Backpressure: none.
module tb_uart_operand_rx;

   localparam int DW = 381;
   localparam int NB = 48;

   localparam int EV_ARM   = 0;
   localparam int EV_ABORT = 1;
   localparam int EV_OK    = 2;
   localparam int EV_BAD   = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          RxD;
   logic [DW-1:0] RxData;
   logic          done;
   logic          frame_err;

   always #5 clk = ~clk;

   uart_operand_rx #(
      .CLK_FREQ (160),
      .BAUD     (10),
      .DATA_W   (DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .RxD       (RxD),
      .RxData    (RxData),
      .done      (done),
      .frame_err (frame_err)
   );

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      int         kind;
      logic [7:0] b;
   } ev_t;

   ev_t evq[$];

   // Operand-level model: what the outputs must be, event by event.
   logic [DW-1:0] m_data;
   logic          m_done;
   logic          m_ferr;
   logic          m_armed;
   int            m_cnt;

   task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s @cyc %0d: got %b want %b", name, cyc, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
   endtask

   // Compare process: apply due model events, then check every cycle.
   initial begin
      ev_t e;
      m_data  = '0;
      m_done  = 1'b0;
      m_ferr  = 1'b0;
      m_armed = 1'b0;
      m_cnt   = 0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            m_data  = '0;
            m_done  = 1'b0;
            m_ferr  = 1'b0;
            m_armed = 1'b0;
            m_cnt   = 0;
            evq.delete();
         end else begin
            while (evq.size() > 0 && evq[0].due <= cyc) begin
               e = evq.pop_front();
               case (e.kind)
                  EV_ARM: begin
                     m_armed = 1'b1;
                     m_done  = 1'b0;
                     m_ferr  = 1'b0;
                     m_cnt   = 0;
                  end
                  EV_ABORT: begin
                     if (!m_done) begin
                        m_armed = 1'b0;
                        m_cnt   = 0;
                     end
                  end
                  EV_BAD: begin
                     if (m_armed && !m_done) m_ferr = 1'b1;
                  end
                  default: begin
                     if (m_armed && !m_done) begin
                        for (int j = 0; j < 8; j++)
                           if (8 * m_cnt + j < DW) m_data[8 * m_cnt + j] = e.b[j];
                        m_cnt++;
                        if (m_cnt == NB) m_done = 1'b1;
                     end
                  end
               endcase
            end
         end
         check_word("cyc_RxData", RxData, m_data);
         check_bit("cyc_done", done, m_done);
         check_bit("cyc_frame_err", frame_err, m_ferr);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_arm();
      enable = 1'b1;
      evq.push_back('{cyc + 1, EV_ARM, 8'h00});
      tick(4);
   endtask

   task automatic do_disarm();
      enable = 1'b0;
      evq.push_back('{cyc + 1, EV_ABORT, 8'h00});
      tick(4);
   endtask

   task automatic send(input logic [7:0] b, input logic good);
      evq.push_back('{cyc + 156, good ? EV_OK : EV_BAD, b});
      RxD = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         tick(16);
      end
      RxD = good;
      tick(16);
      RxD = 1'b1;
      if (!good) tick(32);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      RxD    = 1'b1;
      tick(3);
      check_word("reset_RxData", RxData, '0);
      check_bit("reset_done", done, 1'b0);
      check_bit("reset_frame_err", frame_err, 1'b0);
      reset = 1'b0;
      tick(4);

      // Full capture of 0xFF bytes.
      do_arm();
      for (int k = 0; k < NB; k++) send(8'hFF, 1'b1);
      tick(4);
      check_word("full_data", RxData, {DW{1'b1}});
      check_bit("full_done", done, 1'b1);
      check_bit("full_ferr", frame_err, 1'b0);

      // False start glitch, then byte order 0x01..0x30.
      do_disarm();
      do_arm();
      check_bit("arm_clears_done", done, 1'b0);
      RxD = 1'b0;
      tick(4);
      RxD = 1'b1;
      tick(30);
      for (int k = 0; k < NB; k++) send(8'(k + 1), 1'b1);
      tick(4);
      check_int("order_b0", int'(RxData[7:0]), 'h01);
      check_int("order_b1", int'(RxData[15:8]), 'h02);
      check_int("order_top", int'(RxData[380:376]), 'h10);
      check_bit("order_done", done, 1'b1);

      // Framing error on byte 5, then resend.
      do_disarm();
      do_arm();
      for (int k = 0; k < NB; k++) begin
         if (k == 5) begin
            send(8'(k * 7 + 3), 1'b0);
            check_bit("ferr_set", frame_err, 1'b1);
            check_bit("ferr_not_done", done, 1'b0);
         end
         send(8'(k * 7 + 3), 1'b1);
      end
      tick(4);
      check_bit("ferr_sticky", frame_err, 1'b1);
      check_bit("ferr_done", done, 1'b1);
      check_int("ferr_b0", int'(RxData[7:0]), 'h03);
      check_int("ferr_b1", int'(RxData[15:8]), 'h0A);
      check_int("ferr_b5", int'(RxData[47:40]), 'h26);
      check_int("ferr_top", int'(RxData[380:376]), 'h0C);

      // Abort after 10 bytes, then re-arm with 0xA5.
      do_disarm();
      do_arm();
      for (int k = 0; k < 10; k++) send(8'h3C, 1'b1);
      do_disarm();
      tick(40);
      check_bit("abort_done", done, 1'b0);
      check_int("abort_partial", int'(RxData[7:0]), 'h3C);
      check_int("abort_old_hi", int'(RxData[87:80]), 'h49);
      do_arm();
      for (int k = 0; k < NB; k++) send(8'hA5, 1'b1);
      tick(4);
      check_int("rearm_b0", int'(RxData[7:0]), 'hA5);
      check_int("rearm_top", int'(RxData[380:376]), 'h05);
      check_bit("rearm_done", done, 1'b1);

      // Async reset during DATA.
      do_disarm();
      do_arm();
      RxD = 1'b0;
      tick(16);
      RxD = 1'b1;
      tick(16);
      RxD = 1'b0;
      tick(10);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_word("rst_RxData", RxData, '0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_ferr", frame_err, 1'b0);
      @(negedge clk);
      #2 reset = 1'b0;
      RxD = 1'b1;
      tick(40);
      send(8'h5A, 1'b1);
      tick(4);
      check_word("rst_idle_RxData", RxData, '0);
      check_bit("rst_idle_done", done, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
